// File: rtl/multicycle_control.sv
// Multi-cycle MIPS control unit: walks each instruction through
// FETCH/DECODE/EXEC/MEM/WB, stalls on the shared memory ready handshake
// (with an optional timeout into HALT), and counts retired instructions.
module multicycle_control #(
    parameter int ALU_OP_WIDTH = 2,
    parameter int CNT_WIDTH    = 32,
    parameter int MEM_TIMEOUT  = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [5:0]              opcode,
    input  logic                    mem_ready,
    output logic                    reg_wr_en,
    output logic                    reg_dest,
    output logic                    mem_wr_en,
    output logic                    mem_to_reg,
    output logic                    mem_read_en,
    output logic                    alu_in_sel,
    output logic                    jump_en,
    output logic                    branch_en,
    output logic [ALU_OP_WIDTH-1:0] alu_opcode,
    output logic                    ir_wr_en,
    output logic                    pc_inc_en,
    output logic                    illegal_op,
    output logic                    mem_fault,
    output logic                    halted,
    output logic [2:0]              state,
    output logic [CNT_WIDTH-1:0]    retired
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_HALT  = 6'b111111;

    // Timeout compare value; only meaningful when the timeout is enabled.
    localparam logic [31:0] WAIT_LAST  = 32'(MEM_TIMEOUT - 1);
    localparam bit          TIMEOUT_EN = (MEM_TIMEOUT > 0);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    state_t                 state_q, state_d;
    logic [5:0]             op_q, op_d;
    logic [CNT_WIDTH-1:0]   retired_q;
    logic                   fault_q;
    logic [31:0]            wait_q, wait_d;
    logic                   retire;
    logic                   fault_set;
    logic                   timeout_hit;

    // Opcodes that continue into EXEC after DECODE.
    function automatic logic is_exec_op(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_ADDI) || (op == OP_LW) ||
               (op == OP_SW) || (op == OP_BEQ);
    endfunction

    function automatic logic is_legal_op(input logic [5:0] op);
        return is_exec_op(op) || (op == OP_J) || (op == OP_HALT);
    endfunction

    // The deadline cycle only faults if memory is still not ready (ready wins).
    assign timeout_hit = TIMEOUT_EN && !mem_ready && (wait_q == WAIT_LAST);

    // Next-state, opcode latch, retire and wait-counter decisions.
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        retire    = 1'b0;
        fault_set = 1'b0;
        case (state_q)
            S_FETCH: begin
                if (mem_ready) begin
                    state_d = S_DECODE;
                end else if (timeout_hit) begin
                    state_d   = S_HALT;
                    fault_set = 1'b1;
                end
            end
            S_DECODE: begin
                op_d = opcode;
                if (opcode == OP_J) begin
                    state_d = S_FETCH;
                    retire  = 1'b1;
                end else if (opcode == OP_HALT) begin
                    state_d = S_HALT;
                    retire  = 1'b1;
                end else if (is_exec_op(opcode)) begin
                    state_d = S_EXEC;
                end else begin
                    // Undefined opcode is dropped without retiring.
                    state_d = S_FETCH;
                end
            end
            S_EXEC: begin
                case (op_q)
                    OP_BEQ: begin
                        state_d = S_FETCH;
                        retire  = 1'b1;
                    end
                    OP_LW, OP_SW:     state_d = S_MEM;
                    OP_RTYPE, OP_ADDI: state_d = S_WB;
                    default:          state_d = S_FETCH;
                endcase
            end
            S_MEM: begin
                if (mem_ready && (op_q == OP_LW)) begin
                    state_d = S_WB;
                end else if (mem_ready && (op_q == OP_SW)) begin
                    state_d = S_FETCH;
                    retire  = 1'b1;
                end else if (timeout_hit) begin
                    state_d   = S_HALT;
                    fault_set = 1'b1;
                end
            end
            S_WB: begin
                state_d = S_FETCH;
                retire  = 1'b1;
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_FETCH;
        endcase

        // Counter runs only while a memory-facing state keeps stalling;
        // any entry into FETCH or MEM starts it from zero.
        if (((state_q == S_FETCH) || (state_q == S_MEM)) && (state_d == state_q)) begin
            wait_d = wait_q + 32'd1;
        end else begin
            wait_d = 32'd0;
        end
    end

    // Control state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_FETCH;
            op_q      <= 6'd0;
            retired_q <= '0;
            fault_q   <= 1'b0;
            wait_q    <= 32'd0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            wait_q  <= wait_d;
            fault_q <= fault_q | fault_set;
            if (retire) begin
                retired_q <= retired_q + CNT_WIDTH'(1);
            end
        end
    end

    // Moore control decode; everything reads 0 while reset is held.
    always_comb begin
        reg_wr_en   = 1'b0;
        reg_dest    = 1'b0;
        mem_wr_en   = 1'b0;
        mem_to_reg  = 1'b0;
        mem_read_en = 1'b0;
        alu_in_sel  = 1'b0;
        jump_en     = 1'b0;
        branch_en   = 1'b0;
        alu_opcode  = '0;
        ir_wr_en    = 1'b0;
        pc_inc_en   = 1'b0;
        illegal_op  = 1'b0;
        halted      = 1'b0;
        if (!rst) begin
            case (state_q)
                S_FETCH: begin
                    mem_read_en = 1'b1;
                    ir_wr_en    = mem_ready;
                    pc_inc_en   = mem_ready;
                end
                S_DECODE: begin
                    // op_q is not loaded until this edge, so decode the live opcode.
                    jump_en    = (opcode == OP_J);
                    illegal_op = !is_legal_op(opcode);
                end
                S_EXEC: begin
                    if (op_q == OP_RTYPE) begin
                        alu_opcode = ALU_OP_WIDTH'(2);
                        alu_in_sel = 1'b0;
                    end else begin
                        alu_opcode = '0;
                        alu_in_sel = 1'b1;
                    end
                    branch_en = (op_q == OP_BEQ);
                end
                S_MEM: begin
                    alu_in_sel  = 1'b1;
                    mem_read_en = (op_q == OP_LW);
                    mem_wr_en   = (op_q == OP_SW);
                end
                S_WB: begin
                    reg_wr_en  = 1'b1;
                    reg_dest   = (op_q == OP_RTYPE);
                    mem_to_reg = (op_q == OP_LW);
                end
                S_HALT:  halted = 1'b1;
                default: ;
            endcase
        end
    end

    assign state     = rst ? 3'd0 : state_q;
    assign retired   = rst ? '0 : retired_q;
    assign mem_fault = !rst && fault_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: directed scenarios followed by random
// instruction streams, compared every cycle against a route-based model.
module tb_multicycle_control;

    localparam int CW = 4;
    localparam int TO = 4;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_HALT = 6'b111111;
    localparam logic [5:0] OP_BAD  = 6'b111110;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst = 1'b1;
    logic [5:0]    opcode = 6'd0;
    logic          mem_ready = 1'b0;
    logic          reg_wr_en, reg_dest, mem_wr_en, mem_to_reg, mem_read_en;
    logic          alu_in_sel, jump_en, branch_en, ir_wr_en, pc_inc_en;
    logic          illegal_op, mem_fault, halted;
    logic [1:0]    alu_opcode;
    logic [2:0]    state;
    logic [CW-1:0] retired;

    multicycle_control #(.ALU_OP_WIDTH(2), .CNT_WIDTH(CW), .MEM_TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
        .reg_wr_en(reg_wr_en), .reg_dest(reg_dest), .mem_wr_en(mem_wr_en),
        .mem_to_reg(mem_to_reg), .mem_read_en(mem_read_en), .alu_in_sel(alu_in_sel),
        .jump_en(jump_en), .branch_en(branch_en), .alu_opcode(alu_opcode),
        .ir_wr_en(ir_wr_en), .pc_inc_en(pc_inc_en), .illegal_op(illegal_op),
        .mem_fault(mem_fault), .halted(halted), .state(state), .retired(retired)
    );

    int vectors = 0;
    int miscompares = 0;

    // Reference model: current phase number plus the list of phases still
    // to visit for the instruction in flight.
    int         m_cur = 0;
    logic [5:0] m_op = 6'd0;
    int         m_route[$];
    int         m_waits = 0;
    int         m_retired = 0;
    bit         m_fault = 1'b0;

    function automatic bit legal(input logic [5:0] op);
        return op == OP_R || op == OP_J || op == OP_BEQ || op == OP_ADDI ||
               op == OP_LW || op == OP_SW || op == OP_HALT;
    endfunction

    function automatic logic [13:0] exp_ctrl(input logic r, input logic [5:0] op_in,
                                             input logic rdy);
        logic rw, rd, mw, m2r, mr, ais, je, be, ir, pc, ill, hlt;
        logic [1:0] alu;
        {rw, rd, mw, m2r, mr, ais, je, be, ir, pc, ill, hlt} = '0;
        alu = 2'b00;
        if (!r) begin
            if (m_cur == 0) begin
                mr = 1'b1; ir = rdy; pc = rdy;
            end else if (m_cur == 1) begin
                je = (op_in == OP_J); ill = !legal(op_in);
            end else if (m_cur == 2) begin
                alu = (m_op == OP_R) ? 2'b10 : 2'b00;
                ais = (m_op != OP_R);
                be  = (m_op == OP_BEQ);
            end else if (m_cur == 3) begin
                ais = 1'b1; mr = (m_op == OP_LW); mw = (m_op == OP_SW);
            end else if (m_cur == 4) begin
                rw = 1'b1; rd = (m_op == OP_R); m2r = (m_op == OP_LW);
            end else if (m_cur == 5) begin
                hlt = 1'b1;
            end
        end
        return {rw, rd, mw, m2r, mr, ais, je, be, alu, ir, pc, ill, hlt};
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic check_outputs();
        logic [13:0] obs;
        obs = {reg_wr_en, reg_dest, mem_wr_en, mem_to_reg, mem_read_en, alu_in_sel,
               jump_en, branch_en, alu_opcode, ir_wr_en, pc_inc_en, illegal_op, halted};
        check_eq("ctrl", 32'(obs), 32'(exp_ctrl(rst, opcode, mem_ready)));
        check_eq("state", 32'(state), rst ? 32'd0 : 32'(m_cur));
        check_eq("retired", 32'(retired), rst ? 32'd0 : 32'(m_retired % (1 << CW)));
        check_eq("mem_fault", 32'(mem_fault), rst ? 32'd0 : 32'(m_fault));
    endtask

    task automatic model_step(input logic r, input logic [5:0] op, input logic rdy);
        bit ok;
        ok = 1'b1;
        if (r) begin
            m_cur = 0; m_route.delete(); m_op = 6'd0; m_waits = 0;
            m_retired = 0; m_fault = 1'b0;
        end else if (m_cur == 5) begin
            m_cur = 5;
        end else if ((m_cur == 0 || m_cur == 3) && !rdy) begin
            m_waits++;
            if (TO > 0 && m_waits == TO) begin
                m_cur = 5; m_fault = 1'b1; m_route.delete();
            end
        end else begin
            m_waits = 0;
            if (m_cur == 0) begin
                m_cur = 1;
            end else begin
                if (m_cur == 1) begin
                    m_op = op;
                    m_route.delete();
                    ok = legal(op);
                    case (op)
                        OP_R, OP_ADDI: begin m_route.push_back(2); m_route.push_back(4); end
                        OP_LW: begin m_route.push_back(2); m_route.push_back(3); m_route.push_back(4); end
                        OP_SW: begin m_route.push_back(2); m_route.push_back(3); end
                        OP_BEQ: m_route.push_back(2);
                        OP_HALT: m_route.push_back(5);
                        default: ;
                    endcase
                end else begin
                    void'(m_route.pop_front());
                end
                if (m_route.size() == 0) begin
                    m_cur = 0;
                    if (ok) m_retired++;
                end else begin
                    m_cur = m_route[0];
                    if (m_cur == 5) m_retired++;
                end
            end
        end
    endtask

    // One clock: drive on the falling edge, check, then advance the model
    // just after the rising edge.
    task automatic tick(input logic r, input logic [5:0] op, input logic rdy);
        @(negedge clk);
        rst = r; opcode = op; mem_ready = rdy;
        #1;
        check_outputs();
        @(posedge clk);
        #1;
        model_step(r, op, rdy);
    endtask

    task automatic run_instr(input logic [5:0] op, input int fstalls, input int mstalls,
                             output int cycles);
        int n;
        int s;
        logic rdy;
        logic [5:0] opv;
        n = 0;
        s = mstalls;
        for (int i = 0; i < fstalls; i++) begin
            tick(1'b0, 6'($urandom), 1'b0);
            n++;
        end
        do begin
            rdy = 1'b1;
            if (m_cur == 3 && s > 0) begin
                rdy = 1'b0;
                s--;
            end
            opv = (m_cur == 1) ? op : 6'($urandom);
            tick(1'b0, opv, rdy);
            n++;
        end while (m_cur != 0 && m_cur != 5 && n < 60);
        check_eq("instr_bound", 32'(n < 60), 32'd1);
        cycles = n;
    endtask

    initial begin
        int n;
        int k;
        logic [5:0] op;

        // Reset: all outputs held at 0 even with mem_ready high.
        tick(1'b1, 6'd0, 1'b0);
        tick(1'b1, 6'h3f, 1'b1);

        // R-type with memory always ready.
        run_instr(OP_R, 0, 0, n);
        check_eq("rtype_latency", 32'(n), 32'd4);
        check_eq("rtype_retired", 32'(retired), 32'd1);

        // lw with three MEM stalls; the fourth MEM cycle hits the deadline
        // with ready high and must complete.
        run_instr(OP_LW, 0, 3, n);
        check_eq("lw_latency", 32'(n), 32'd8);
        check_eq("lw_retired", 32'(retired), 32'd2);

        run_instr(OP_SW, 0, 0, n);
        check_eq("sw_latency", 32'(n), 32'd4);
        run_instr(OP_BEQ, 0, 0, n);
        check_eq("beq_latency", 32'(n), 32'd3);
        check_eq("sw_beq_retired", 32'(retired), 32'd4);

        run_instr(OP_BAD, 0, 0, n);
        check_eq("illegal_latency", 32'(n), 32'd2);
        check_eq("illegal_retired", 32'(retired), 32'd4);

        run_instr(OP_ADDI, 0, 0, n);
        check_eq("addi_latency", 32'(n), 32'd4);
        run_instr(OP_J, 0, 0, n);
        check_eq("j_latency", 32'(n), 32'd2);
        run_instr(OP_LW, 2, 1, n);
        check_eq("lw_stall_latency", 32'(n), 32'd8);
        check_eq("mixed_retired", 32'(retired), 32'd7);

        // FETCH timeout into HALT, then reset recovery.
        for (int i = 0; i < 4; i++) tick(1'b0, 6'($urandom), 1'b0);
        check_eq("fetch_to_state", 32'(state), 32'd5);
        check_eq("fetch_to_fault", 32'(mem_fault), 32'd1);
        check_eq("fetch_to_halted", 32'(halted), 32'd1);
        tick(1'b0, 6'($urandom), 1'b1);
        tick(1'b1, 6'd0, 1'b0);
        tick(1'b0, 6'd0, 1'b0);

        // MEM timeout on a store.
        run_instr(OP_SW, 0, 4, n);
        check_eq("mem_to_latency", 32'(n), 32'd7);
        check_eq("mem_to_fault", 32'(mem_fault), 32'd1);
        tick(1'b1, 6'd0, 1'b1);

        // Retire counter wrap at 4 bits.
        for (int i = 0; i < 15; i++) begin
            k = i % 5;
            op = (k == 0) ? OP_R : (k == 1) ? OP_LW : (k == 2) ? OP_SW :
                 (k == 3) ? OP_BEQ : OP_J;
            run_instr(op, 0, 0, n);
        end
        check_eq("retired_full", 32'(retired), 32'd15);
        run_instr(OP_J, 0, 0, n);
        check_eq("retired_wrap", 32'(retired), 32'd0);

        // HALT opcode: sticks in HALT whatever the inputs do.
        run_instr(OP_HALT, 0, 0, n);
        check_eq("halt_latency", 32'(n), 32'd2);
        check_eq("halt_retired", 32'(retired), 32'd1);
        for (int i = 0; i < 10; i++) tick(1'b0, 6'($urandom), 1'($urandom));
        check_eq("halt_state", 32'(state), 32'd5);
        check_eq("halt_halted", 32'(halted), 32'd1);
        check_eq("halt_no_fault", 32'(mem_fault), 32'd0);
        tick(1'b1, 6'd0, 1'b0);

        // Random instruction stream with random stalls.
        for (int i = 0; i < 300; i++) begin
            k = $urandom_range(0, 15);
            if (k <= 2)       op = OP_R;
            else if (k <= 4)  op = OP_ADDI;
            else if (k <= 7)  op = OP_LW;
            else if (k <= 10) op = OP_SW;
            else if (k <= 12) op = OP_BEQ;
            else if (k == 13) op = OP_J;
            else if (k == 14) begin
                op = 6'($urandom);
                if (legal(op)) op = OP_BAD;
            end else op = OP_HALT;
            run_instr(op, $urandom_range(0, 2), $urandom_range(0, 4), n);
            if (m_cur == 5) begin
                for (int j = 0; j < int'($urandom_range(1, 3)); j++)
                    tick(1'b0, 6'($urandom), 1'($urandom));
                tick(1'b1, 6'($urandom), 1'($urandom));
            end
        end

        // Abort mid-instruction with reset: no retire.
        tick(1'b0, 6'd0, 1'b1);
        tick(1'b0, OP_LW, 1'b1);
        tick(1'b1, 6'd0, 1'b1);
        tick(1'b0, 6'd0, 1'b0);
        check_eq("abort_retired", 32'(retired), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Multi-cycle successor to the single-cycle opcode decoder.
- Sequences each MIPS instruction through FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK states.
- Waits on a shared memory ready handshake, with an optional timeout.
- Latches the opcode, counts retired instructions, and drives defined 0s for illegal/halt opcodes (no z).
- Sits between the instruction register/unified memory port and the datapath.

Parameters:
- ALU_OP_WIDTH, 2: width of alu_opcode.
- CNT_WIDTH, 32: width of retired-instruction counter.
- MEM_TIMEOUT, 0: max cycles waiting for mem_ready before fault; 0 disables the timeout.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- opcode  input  6  instr[31:26] from the instruction register; valid in DECODE.
- mem_ready  input  1  memory has completed the current read/write this cycle.
- reg_wr_en, reg_dest, mem_wr_en, mem_to_reg, mem_read_en, alu_in_sel, jump_en, branch_en  output  1 each  datapath controls, same meaning as the single-cycle decoder.
- alu_opcode  output  ALU_OP_WIDTH  00 add, 10 funct-decoded.
- ir_wr_en  output  1  load the instruction register.
- pc_inc_en  output  1  PC <= PC+4.
- illegal_op  output  1  one-cycle pulse on an undefined opcode.
- mem_fault  output  1  sticky; memory timeout occurred.
- halted  output  1  high in HALT.
- state  output  3  current state, for debug.
- retired  output  CNT_WIDTH  count of completed instructions.

Behaviour:
- State encoding: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5. Codes 6 and 7 are unreachable and go to FETCH.
- Outputs are Moore-decoded from state and op_q (the opcode latched on the DECODE edge). Later changes on opcode are ignored.
- Reset: state=FETCH, op_q=0, retired=0, mem_fault=0, wait counter=0. While rst=1 all outputs are forced to 0. This includes state, which reads 0 because FETCH=0.
- Asserted per state (all other controls 0):
  - FETCH: mem_read_en=1. ir_wr_en=pc_inc_en=mem_ready. Go to DECODE when mem_ready=1, else stay.
  - DECODE:
    - op_q loads opcode.
    - j (000010): jump_en=1, go to FETCH, retire.
    - halt (111111): go to HALT, retire.
    - 000000, 001000, 100011, 101011, 000100: go to EXEC.
    - Any other opcode: illegal_op=1, go to FETCH, no retire, no writes.
  - EXEC:
    - R-type: alu_opcode=10, alu_in_sel=0.
    - addi/lw/sw/beq: alu_opcode=00, alu_in_sel=1.
    - beq: branch_en=1, go to FETCH, retire.
    - lw/sw: go to MEM.
    - R-type/addi: go to WB.
  - MEM:
    - alu_in_sel=1.
    - lw: mem_read_en=1. Go to WB when mem_ready=1.
    - sw: mem_wr_en=1. Go to FETCH and retire when mem_ready=1.
    - Otherwise stay.
  - WB:
    - reg_wr_en=1.
    - R-type: reg_dest=1.
    - lw: mem_to_reg=1.
    - Go to FETCH, retire.
  - HALT: halted=1, all controls 0. Exit only via rst.
- Latency in cycles with mem_ready always 1: j=2, beq=3, R/addi/sw=4, lw=5. Each extra wait cycle adds 1.
- Wait counter:
  - Clears on entry to FETCH/MEM; increments each cycle in FETCH or MEM with mem_ready=0.
  - If MEM_TIMEOUT>0 and the counter reaches MEM_TIMEOUT-1 with mem_ready still 0, the next state is HALT and mem_fault sets.
  - mem_ready=1 on the deadline cycle completes normally (ready wins).
- Retire: retired increments by 1 on the retiring edge and wraps modulo 2^CNT_WIDTH.
- rst asserted mid-instruction aborts it: no retire, state returns to FETCH.

Test Plan:
- Reset, then R-type (000000) with mem_ready=1 → states 0,1,2,4,0; reg_wr_en=reg_dest=1 in WB only; alu_opcode=10 in EXEC; retired=1.
- lw (100011) with mem_ready low 3 cycles in MEM → MEM held 4 cycles; mem_read_en=1 throughout; WB has mem_to_reg=1; total 8 cycles; retired+1.
- sw (101011) then beq (000100) → sw asserts mem_wr_en only in MEM, reg_wr_en never 1; beq asserts branch_en only in EXEC (3 cycles); retired+2.
- Opcode 111110 → illegal_op pulses 1 cycle in DECODE; no write enables; retired unchanged. Next instruction executes normally.
- MEM_TIMEOUT=4, mem_ready held 0 in FETCH → HALT after 4 FETCH cycles; mem_fault=halted=1. rst then clears both and state=0.
- Set retired to all-ones with CNT_WIDTH=4 (15 instructions), then j → retired wraps to 0. Also: halt opcode → halted=1, state=5, and state stays 5 for 10 cycles despite opcode changes.
